// File: rtl/fifo_param_flow_pkg.sv
// Shared defaults and read-mode constants for the parametrised flow-control FIFO.
package fifo_param_flow_pkg;

  localparam int unsigned FIFO_DATA_SIZE = 12;
  localparam int unsigned FIFO_ADDR_SIZE = 3;

  localparam int unsigned FIFO_MODE_STD  = 0;
  localparam int unsigned FIFO_MODE_FWFT = 1;

endpackage : fifo_param_flow_pkg

// File: rtl/fifo_mem_dp.sv
// DEPTH x DATA_SIZE storage: synchronous write port, asynchronous read port.
module fifo_mem_dp #(
  parameter int unsigned DATA_SIZE = 12,
  parameter int unsigned ADDR_SIZE = 3
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_SIZE-1:0] waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic [ADDR_SIZE-1:0] raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;

  logic [DATA_SIZE-1:0] mem [DEPTH];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule : fifo_mem_dp

// File: rtl/fifo_param_flow.sv
// Parametrised FIFO with programmable almost flags, sticky clearable errors
// and a choice of registered-read or first-word-fall-through output.
module fifo_param_flow
  import fifo_param_flow_pkg::*;
#(
  parameter int unsigned DATA_SIZE = FIFO_DATA_SIZE,
  parameter int unsigned ADDR_SIZE = FIFO_ADDR_SIZE,
  parameter int unsigned FWFT      = FIFO_MODE_STD
) (
  input  logic                 clk,
  input  logic                 reset_L,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [ADDR_SIZE:0]   th_almost_full,
  input  logic [ADDR_SIZE:0]   th_almost_empty,
  input  logic                 err_clear,
  output logic [DATA_SIZE-1:0] fifo_data_out,
  output logic                 fifo_valid,
  output logic [ADDR_SIZE:0]   fifo_count,
  output logic                 fifo_empty,
  output logic                 fifo_full,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 err_overflow,
  output logic                 err_underflow,
  output logic                 fifo_error
);

  localparam int unsigned DEPTH = 2 ** ADDR_SIZE;
  localparam int unsigned CW    = ADDR_SIZE + 1;

  logic [ADDR_SIZE-1:0] wr_ptr;
  logic [ADDR_SIZE-1:0] rd_ptr;
  logic [CW-1:0]        count;
  logic [DATA_SIZE-1:0] mem_rdata;
  logic                 rd_ok;
  logic                 wr_ok;
  logic                 err_ovf_q;
  logic                 err_unf_q;

  // A push onto a full FIFO only goes through alongside an accepted pop.
  always_comb begin
    rd_ok = read && (count != '0);
    wr_ok = write && ((count != CW'(DEPTH)) || rd_ok);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + ADDR_SIZE'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + ADDR_SIZE'(1);
      end
      if (wr_ok && !rd_ok) begin
        count <= count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
        count <= count - CW'(1);
      end
    end
  end

  // Sticky errors; a fresh error in the clearing cycle takes priority.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      err_ovf_q <= (write && !wr_ok) || (err_ovf_q && !err_clear);
      err_unf_q <= (read && !rd_ok) || (err_unf_q && !err_clear);
    end
  end

  fifo_mem_dp #(
    .DATA_SIZE (DATA_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (data_in),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  assign fifo_count    = count;
  assign fifo_empty    = (count == '0);
  assign fifo_full     = (count == CW'(DEPTH));
  assign almost_full   = (count >= th_almost_full);
  assign almost_empty  = (count <= th_almost_empty);
  assign err_overflow  = err_ovf_q;
  assign err_underflow = err_unf_q;
  assign fifo_error    = err_ovf_q || err_unf_q;

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      assign fifo_data_out = mem_rdata;
      assign fifo_valid    = !fifo_empty;
    end else begin : g_std
      logic [DATA_SIZE-1:0] dout_q;
      logic                 valid_q;

      // Popped word is captured at the accepting edge and held until the next pop.
      always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
          dout_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= rd_ok;
          if (rd_ok) begin
            dout_q <= mem_rdata;
          end
        end
      end

      assign fifo_data_out = dout_q;
      assign fifo_valid    = valid_q;
    end
  endgenerate

endmodule : fifo_param_flow
